// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and sizes for the mul/div sequencer
// Contents: default operand width, counter width, op encodings, FSM state encoding.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage request/response bundle for the mul/div sequencer
// master: EX stage (drives start/op/operands/MTHI/MTLO/flush)
// slave : muldiv_controller (drives stall/busy/done/divzero/HI/LO)
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             EX_MulDivStart;
    logic [1:0]       EX_MulDivOp;
    logic [WIDTH-1:0] EX_OpA;
    logic [WIDTH-1:0] EX_OpB;
    logic             EX_HiWrite;
    logic             EX_LoWrite;
    logic             EX_Flush;

    logic             MulDivStall;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output EX_MulDivStart, EX_MulDivOp, EX_OpA, EX_OpB,
               EX_HiWrite, EX_LoWrite, EX_Flush,
        input  MulDivStall, Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  EX_MulDivStart, EX_MulDivOp, EX_OpA, EX_OpB,
               EX_HiWrite, EX_LoWrite, EX_Flush,
        output MulDivStall, Busy, Done, DivZero, HI, LO
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-divide iteration
// Ports: acc_i accumulator/remainder, opnd_i multiplicand/divisor,
//        mq_bit_i multiplier LSB (mul) or next dividend MSB (div), is_div_i op class,
//        acc_o next accumulator/remainder, bit_o product bit shifted out (mul) or quotient bit (div).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             mq_bit_i,
    input  logic             is_div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             bit_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then the
        // {acc, mq} pair shifts right by one; sum[0] becomes the new mq MSB.
        sum     = {1'b0, acc_i} + (mq_bit_i ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        // Divide: bring the next dividend bit into the partial remainder.
        shifted = {acc_i, mq_bit_i};
        // When shifted >= divisor the true difference is below the divisor,
        // so the low WIDTH bits of the subtraction are exact.
        diff    = shifted[WIDTH-1:0] - opnd_i;
        ge      = shifted >= {1'b0, opnd_i};
        if (is_div_i) begin
            acc_o = ge ? diff : shifted[WIDTH-1:0];
            bit_o = ge;
        end else begin
            acc_o = sum[WIDTH:1];
            bit_o = sum[0];
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
// Ports: Clock, Reset (sync, active-high), bus (muldiv_if.slave): EX start/op/operands,
//        MTHI/MTLO writes, flush in; stall, busy, done pulse, sticky divide-by-zero, HI/LO out.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic     Clock,
    input logic     Reset,
    muldiv_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;        // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic             start_ok;
    logic             op_div;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             step_mq_bit;
    logic             step_bit;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_mq;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign start_ok  = bus.EX_MulDivStart & ~bus.EX_Flush;
    assign op_div    = (bus.EX_MulDivOp == OP_DIV) | (bus.EX_MulDivOp == OP_DIVU);
    assign op_signed = (bus.EX_MulDivOp == OP_MULT) | (bus.EX_MulDivOp == OP_DIV);
    assign a_neg     = op_signed & bus.EX_OpA[WIDTH-1];
    assign b_neg     = op_signed & bus.EX_OpB[WIDTH-1];
    // MIN_INT stays 0x80..0 after negation, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? -bus.EX_OpA : bus.EX_OpA;
    assign b_mag     = b_neg ? -bus.EX_OpB : bus.EX_OpB;

    // Multiply consumes the multiplier from the LSB; divide consumes the dividend from the MSB.
    assign step_mq_bit = is_div_q ? mq_q[WIDTH-1] : mq_q[0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .mq_bit_i (step_mq_bit),
        .is_div_i (is_div_q),
        .acc_o    (step_acc),
        .bit_o    (step_bit)
    );

    assign step_mq  = is_div_q ? {mq_q[WIDTH-2:0], step_bit} : {step_bit, mq_q[WIDTH-1:1]};

    // Sign fix-up operates on the final step's output so HI/LO commit in the last BUSY cycle.
    assign prod     = {step_acc, step_mq};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quo_fix  = neg_res_q ? -step_mq : step_mq;
    assign rem_fix  = neg_rem_q ? -step_acc : step_acc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    dz_d      = 1'b0;
                    is_div_d  = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = '0;
                    cnt_d     = CNT_LAST;
                    if (op_div) begin
                        mq_d   = a_mag;
                        opnd_d = b_mag;
                        if (bus.EX_OpB == '0) begin
                            hi_d    = bus.EX_OpA;
                            lo_d    = '1;
                            dz_d    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end else begin
                        mq_d    = b_mag;
                        opnd_d  = a_mag;
                        state_d = S_BUSY;
                    end
                end else if (!bus.EX_MulDivStart) begin
                    // A raw Start (even a flushed one) blocks MTHI/MTLO in the same cycle.
                    if (bus.EX_HiWrite) hi_d = bus.EX_OpA;
                    if (bus.EX_LoWrite) lo_d = bus.EX_OpA;
                end
            end

            S_BUSY: begin
                if (bus.EX_Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    if (cnt_q == '0) begin
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            S_DONE: begin
                // The finishing instruction is still in EX here, so Start is ignored.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    // Combinational so the start cycle itself holds the pipeline.
    assign bus.MulDivStall = ((state_q == S_IDLE) & start_ok) | (state_q == S_BUSY);
    assign bus.Busy        = (state_q == S_BUSY);
    assign bus.Done        = (state_q == S_DONE);
    assign bus.DivZero     = dz_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// tb/tb_muldiv_controller.sv - scoreboard bench for muldiv_controller
module tb_muldiv_controller;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_controller #(.WIDTH(W)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    int   op_id     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.Done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: Done=1 with nothing pending, HI=0x%0h LO=0x%0h", bus.HI, bus.LO);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("hi[op%0d]", e.id), 64'(bus.HI), 64'(e.hi));
                check($sformatf("lo[op%0d]", e.id), 64'(bus.LO), 64'(e.lo));
                check($sformatf("divzero[op%0d]", e.id), 64'(bus.DivZero), 64'(e.dz));
            end
        end
    end

    // Issues one op with Start for one cycle (or held through DONE when hold=1),
    // measures the stall length and checks Done arrives right after it.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int estall, input bit hold, input bit lo_wr, input logic [W-1:0] lo_prev);
        exp_t e;
        int   stall_n;
        int   guard;
        op_id++;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.id = op_id;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.EX_MulDivStart = 1'b1;
        bus.EX_MulDivOp    = op;
        bus.EX_OpA         = a;
        bus.EX_OpB         = b;
        bus.EX_LoWrite     = lo_wr;
        @(negedge clk);
        check($sformatf("stall_start[op%0d]", op_id), 64'(bus.MulDivStall), 64'd1);
        stall_n = 1;
        @(posedge clk); #1;
        if (!hold) bus.EX_MulDivStart = 1'b0;
        bus.EX_LoWrite = 1'b0;
        guard = 0;
        forever begin
            @(negedge clk);
            if (lo_wr && guard == 0)
                check($sformatf("lowrite_dropped[op%0d]", op_id), 64'(bus.LO), 64'(lo_prev));
            if (!bus.MulDivStall) break;
            stall_n++;
            guard++;
            if (hold && stall_n == 5) begin
                bus.EX_OpA = 32'h0000_0055;
                bus.EX_OpB = 32'h0000_0077;
            end
            if (guard > 100) begin
                $display("FAIL stall_timeout[op%0d]: stall still high after %0d cycles, expected %0d", op_id, stall_n, estall);
                n_checks++;
                n_fail++;
                break;
            end
        end
        check($sformatf("stall_len[op%0d]", op_id), 64'(stall_n), 64'(estall));
        check($sformatf("done_cycle[op%0d]", op_id), 64'(bus.Done), 64'd1);
        if (hold) begin
            @(posedge clk); #1;
            bus.EX_MulDivStart = 1'b0;
        end
    endtask

    initial begin
        int done_before;
        rst = 1'b1;
        bus.EX_MulDivStart = 1'b0;
        bus.EX_MulDivOp    = OP_MULT;
        bus.EX_OpA         = '0;
        bus.EX_OpB         = '0;
        bus.EX_HiWrite     = 1'b0;
        bus.EX_LoWrite     = 1'b0;
        bus.EX_Flush       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi",    64'(bus.HI), 64'd0);
        check("rst_lo",    64'(bus.LO), 64'd0);
        check("rst_busy",  64'(bus.Busy), 64'd0);
        check("rst_done",  64'(bus.Done), 64'd0);
        check("rst_stall", 64'(bus.MulDivStall), 64'd0);
        check("rst_dz",    64'(bus.DivZero), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MTHI / MTLO
        @(posedge clk); #1;
        bus.EX_HiWrite = 1'b1;
        bus.EX_OpA     = 32'h0000_1234;
        @(negedge clk);
        check("mthi_no_stall", 64'(bus.MulDivStall), 64'd0);
        @(posedge clk); #1;
        bus.EX_HiWrite = 1'b0;
        bus.EX_LoWrite = 1'b1;
        bus.EX_OpA     = 32'h0000_ABCD;
        @(negedge clk);
        check("mthi_hi", 64'(bus.HI), 64'h1234);
        @(posedge clk); #1;
        bus.EX_LoWrite = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(bus.LO), 64'hABCD);
        check("mtlo_hi_kept", 64'(bus.HI), 64'h1234);

        // Arithmetic vectors: op, A, B, HI, LO, DivZero, stall cycles, hold, LoWrite, prior LO
        run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 33, 1'b0, 1'b1, 32'hFFFF_FFFD);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 33, 1'b0, 1'b0, '0);
        run_op(OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b0, 1'b0, '0);

        // Divide by zero, then sticky DivZero until the next Start
        run_op(OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1,  1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("dz_sticky", 64'(bus.DivZero), 64'd1);
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33, 1'b0, 1'b0, '0);

        // Start held through DONE with operands changed mid-flight
        run_op(OP_MULT,  32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 33, 1'b1, 1'b0, '0);
        @(negedge clk);
        check("hold_idle_stall", 64'(bus.MulDivStall), 64'd0);
        check("hold_idle_busy",  64'(bus.Busy), 64'd0);

        // Flush in BUSY cycle 10
        done_before = done_seen;
        @(posedge clk); #1;
        bus.EX_MulDivStart = 1'b1;
        bus.EX_MulDivOp    = OP_MULT;
        bus.EX_OpA         = 32'd5;
        bus.EX_OpB         = 32'd6;
        @(posedge clk); #1;
        bus.EX_MulDivStart = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.EX_Flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", 64'(bus.Busy), 64'd1);
        @(posedge clk); #1;
        bus.EX_Flush = 1'b0;
        @(negedge clk);
        check("flush_busy",  64'(bus.Busy), 64'd0);
        check("flush_stall", 64'(bus.MulDivStall), 64'd0);
        check("flush_hi",    64'(bus.HI), 64'hFFFF_FFFF);
        check("flush_lo",    64'(bus.LO), 64'hFFFF_FFF4);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_seen - done_before), 64'd0);

        // Reset mid-BUSY
        @(posedge clk); #1;
        bus.EX_MulDivStart = 1'b1;
        bus.EX_MulDivOp    = OP_DIVU;
        bus.EX_OpA         = 32'd1000;
        bus.EX_OpB         = 32'd7;
        @(posedge clk); #1;
        bus.EX_MulDivStart = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_hi",    64'(bus.HI), 64'd0);
        check("rstbusy_lo",    64'(bus.LO), 64'd0);
        check("rstbusy_busy",  64'(bus.Busy), 64'd0);
        check("rstbusy_done",  64'(bus.Done), 64'd0);
        check("rstbusy_stall", 64'(bus.MulDivStall), 64'd0);
        check("rstbusy_dz",    64'(bus.DivZero), 64'd0);
        repeat (40) @(negedge clk);
        check("rstbusy_hi_late", 64'(bus.HI), 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
